// File: rtl/mem_arbiter_if.sv
// Bundled fetch, load/store and shared-memory signals around the instruction/data memory arbiter.
// The slave modport is the arbiter's view; the master modport is the CPU/memory environment's view.
interface mem_arbiter_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_wait;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_wait;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        bus_err;

  modport slave (
    input  imem_req, imem_addr,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  mem_ack, mem_rdata,
    output imem_rdata, imem_ready, imem_wait,
    output dmem_rdata, dmem_ready, dmem_wait,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output bus_err
  );

  modport master (
    output imem_req, imem_addr,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output mem_ack, mem_rdata,
    input  imem_rdata, imem_ready, imem_wait,
    input  dmem_rdata, dmem_ready, dmem_wait,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data loads/stores onto one single-port memory,
// with data priority bounded by a streak limit and a per-transaction timeout.
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  localparam logic [3:0] DSTREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  dstreak_q, dstreak_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        timed_out;
  logic        done;
  logic        mem_req;
  logic        iready, dready;
  logic [31:0] irdata, drdata;

  assign timed_out = (tmo_q == TMO_LAST) && !bus.mem_ack;
  assign done      = bus.mem_ack || timed_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    tmo_d     = tmo_q;
    bus_err_d = bus_err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    mem_req   = 1'b0;
    iready    = 1'b0;
    dready    = 1'b0;
    irdata    = '0;
    drdata    = '0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        // Data wins unless a fetch has already waited out MAX_DSTREAK data grants.
        if (bus.dmem_req && (!bus.imem_req || dstreak_q < DSTREAK_MAX)) begin
          state_d = BUSY_D;
          addr_d  = bus.dmem_addr;
          we_d    = bus.dmem_we;
          wdata_d = bus.dmem_wdata;
          wstrb_d = bus.dmem_wstrb;
          if (!bus.imem_req)
            dstreak_d = '0;
          else if (dstreak_q >= DSTREAK_MAX)
            dstreak_d = DSTREAK_MAX;
          else
            dstreak_d = dstreak_q + 4'd1;
        end else if (bus.imem_req) begin
          state_d   = BUSY_I;
          addr_d    = bus.imem_addr;
          we_d      = 1'b0;
          wdata_d   = '0;
          wstrb_d   = '0;
          dstreak_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        mem_req = 1'b1;
        if (done) begin
          state_d = IDLE;
          tmo_d   = '0;
          if (timed_out)
            bus_err_d = 1'b1;
          if (state_q == BUSY_I) begin
            iready = 1'b1;
            irdata = bus.mem_ack ? bus.mem_rdata : '0;
          end else begin
            dready = 1'b1;
            drdata = bus.mem_ack ? bus.mem_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset abandons any transaction in the same cycle, so no strobe may escape.
    if (reset) begin
      mem_req = 1'b0;
      iready  = 1'b0;
      dready  = 1'b0;
      irdata  = '0;
      drdata  = '0;
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wstrb  = wstrb_q;
  assign bus.imem_ready = iready;
  assign bus.imem_rdata = irdata;
  assign bus.dmem_ready = dready;
  assign bus.dmem_rdata = drdata;
  assign bus.imem_wait  = bus.imem_req & ~iready;
  assign bus.dmem_wait  = bus.dmem_req & ~dready;
  assign bus.bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked cycle by cycle
// against a transaction-level model of the arbitration, timeout and reset rules.
module tb_mem_arbiter;
  localparam int MAXD = 4;
  localparam int TMO  = 8;

  logic clk;
  logic reset;
  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus for the next cycle
  logic        r_rst;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_wstrb;

  // Reference model: who owns the memory (0 none, 1 fetch, 2 data) and for how long
  int          owner, age, streak;
  logic        err;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_we;
  logic [3:0]  lat_wstrb;
  logic        last_iready, last_dready;

  logic        prev_mem_req;
  logic [31:0] grants[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    owner = 0; age = 0; streak = 0; err = 1'b0;
    lat_addr = '0; lat_wdata = '0; lat_we = 1'b0; lat_wstrb = '0;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic cycle();
    logic        fin, eir, edr;
    logic [31:0] eird, edrd;
    @(negedge clk);
    reset          = r_rst;
    bus.imem_req   = i_req;
    bus.imem_addr  = i_addr;
    bus.dmem_req   = d_req;
    bus.dmem_we    = d_we;
    bus.dmem_addr  = d_addr;
    bus.dmem_wdata = d_wdata;
    bus.dmem_wstrb = d_wstrb;
    bus.mem_ack    = m_ack;
    bus.mem_rdata  = m_rdata;
    #1;
    if (bus.mem_req && !prev_mem_req) grants.push_back(bus.mem_addr);
    prev_mem_req = bus.mem_req;

    fin  = !r_rst && owner != 0 && (m_ack || age == TMO - 1);
    eir  = fin && owner == 1;
    edr  = fin && owner == 2;
    eird = (eir && m_ack) ? m_rdata : 32'h0;
    edrd = (edr && m_ack) ? m_rdata : 32'h0;

    check("mem_req",    32'(bus.mem_req),    32'(!r_rst && owner != 0));
    check("imem_ready", 32'(bus.imem_ready), 32'(eir));
    check("dmem_ready", 32'(bus.dmem_ready), 32'(edr));
    check("imem_rdata", bus.imem_rdata, eird);
    check("dmem_rdata", bus.dmem_rdata, edrd);
    check("imem_wait",  32'(bus.imem_wait), 32'(i_req && !eir));
    check("dmem_wait",  32'(bus.dmem_wait), 32'(d_req && !edr));
    check("bus_err",    32'(bus.bus_err),   32'(err));
    if (!r_rst && owner != 0) begin
      check("mem_addr",  bus.mem_addr,         lat_addr);
      check("mem_we",    32'(bus.mem_we),      32'(lat_we));
      check("mem_wstrb", 32'(bus.mem_wstrb),   32'(lat_wstrb));
      if (owner == 2) check("mem_wdata", bus.mem_wdata, lat_wdata);
    end
    last_iready = eir;
    last_dready = edr;

    if (r_rst) begin
      model_reset();
    end else if (owner != 0) begin
      if (fin) begin
        if (!m_ack) err = 1'b1;
        owner = 0;
        age   = 0;
      end else begin
        age++;
      end
    end else if (d_req && (!i_req || streak < MAXD)) begin
      owner = 2; age = 0;
      streak = i_req ? ((streak + 1 > MAXD) ? MAXD : streak + 1) : 0;
      lat_addr = d_addr; lat_we = d_we; lat_wdata = d_wdata; lat_wstrb = d_wstrb;
    end else if (i_req) begin
      owner = 1; age = 0; streak = 0;
      lat_addr = i_addr; lat_we = 1'b0; lat_wdata = '0; lat_wstrb = '0;
    end
  endtask

  task automatic quiet();
    r_rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0; m_rdata = 32'h1234_5678;
  endtask

  task automatic do_reset(input int n);
    r_rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      m_ack = 1'b1;
      cycle();
    end
    r_rst = 1'b0;
    m_ack = 1'b0;
  endtask

  string exp_order;

  initial begin
    quiet();
    model_reset();
    prev_mem_req = 1'b0;
    last_iready  = 1'b0;
    last_dready  = 1'b0;
    do_reset(2);
    cycle();

    // Fetch only, ack in second busy cycle
    i_req = 1'b1; i_addr = 32'h100;
    cycle(); cycle();
    m_ack = 1'b1; m_rdata = 32'h0050_0093;
    cycle();
    check("fetch_strobe", 32'(bus.imem_ready), 32'd1);
    check("fetch_data",   bus.imem_rdata, 32'h0050_0093);
    quiet(); cycle();

    // Simultaneous request with empty streak: data first, fetch right after
    do_reset(1);
    grants.delete();
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h2000;
    cycle(); cycle();
    m_ack = 1'b1; cycle();
    d_req = 1'b0; m_ack = 1'b0;
    cycle(); cycle();
    m_ack = 1'b1; cycle();
    quiet(); cycle();
    check("simul_n", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      check("simul_first",  grants[0], 32'h2000);
      check("simul_second", grants[1], 32'h100);
    end

    // Starvation bound: data held against a waiting fetch
    do_reset(1);
    grants.delete();
    exp_order = "DDDDID";
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h2000;
    for (int t = 0; t < 6; t++) begin
      m_ack = 1'b0; cycle(); cycle();
      m_ack = 1'b1; m_rdata = $urandom(); cycle();
    end
    quiet(); cycle();
    check("order_n", 32'(grants.size()), 32'd6);
    for (int k = 0; k < 6 && k < grants.size(); k++)
      check("order", (grants[k] == 32'h100) ? 32'h49 : 32'h44, 32'(exp_order[k]));

    // Store, ack in third busy cycle
    do_reset(1);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
    cycle(); cycle(); cycle();
    m_ack = 1'b1; cycle();
    check("store_strobe", 32'(bus.dmem_ready), 32'd1);
    quiet(); cycle();

    // Timeout: no ack ever, then a normal fetch
    do_reset(1);
    d_req = 1'b1; d_addr = 32'h4000;
    cycle();
    for (int k = 0; k < TMO; k++) cycle();
    check("tmo_strobe", 32'(bus.dmem_ready), 32'd1);
    check("tmo_data",   bus.dmem_rdata, 32'h0);
    quiet(); cycle();
    check("tmo_err_held", 32'(bus.bus_err), 32'd1);
    i_req = 1'b1; i_addr = 32'h200; cycle();
    m_ack = 1'b1; m_rdata = 32'hCAFE_0001; cycle();
    check("post_tmo_fetch", bus.imem_rdata, 32'hCAFE_0001);
    quiet(); cycle();

    // Reset mid-BUSY_I with a late ack
    do_reset(1);
    i_req = 1'b1; i_addr = 32'h300;
    cycle(); cycle();
    do_reset(1);
    quiet(); m_ack = 1'b1; cycle();
    check("rst_mid_err", 32'(bus.bus_err), 32'd0);
    quiet(); cycle();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      r_rst   = ($urandom_range(0, 499) == 0);
      m_ack   = ($urandom_range(0, 99) < 35);
      m_rdata = $urandom();
      cycle();
      if (last_iready || !i_req) begin
        i_req  = (last_iready ? $urandom_range(0, 1) : $urandom_range(0, 3)) == 0 ? 1'b1 : 1'b0;
        i_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
      end else if ($urandom_range(0, 49) == 0) begin
        i_req = 1'b0;
      end
      if (last_dready || !d_req) begin
        d_req   = ($urandom_range(0, 2) == 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = {$urandom_range(0, 32'h3FFF), 2'b00};
        d_wdata = $urandom();
        d_wstrb = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 49) == 0) begin
        d_req = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
